// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver with a one-entry registered output buffer.
// Define PARITY_EN to append one even-parity bit to every WIDTH-bit word.
module shift_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = WIDTH + (PAR ? 1 : 0);
  localparam int CW = $clog2(FL + 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_shift, word;
  logic [CW-1:0]    cnt;
  logic             acc, last_bit, complete, buf_free;
  logic             par_acc, word_perr, held_perr;

  always_comb begin
    ser_ready = (state == COLLECT);
    acc       = ser_valid && ser_ready;
    last_bit  = (cnt == CW'(FL - 1));
    complete  = acc && !frame_start && last_bit;
    buf_free  = !out_valid || out_ready;
    sr_shift  = LSB_FIRST ? {ser_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], ser_in};
    // With parity the final bit is the check bit, so sr already holds the data.
    word      = PAR ? sr : sr_shift;
    word_perr = PAR ? (par_acc ^ ser_in) : 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (complete && !buf_free) state_nxt = FULL;
      FULL:    if (out_valid && out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      sr         <= '0;
      cnt        <= '0;
      par_acc    <= 1'b0;
      held_perr  <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= (state == COLLECT) && frame_start && (cnt != '0);

      if (state == COLLECT) begin
        if (acc) begin
          if (frame_start) begin
            cnt     <= CW'(1);
            sr      <= sr_shift;
            par_acc <= ser_in;
          end else if (last_bit) begin
            cnt     <= '0;
            par_acc <= 1'b0;
            sr      <= word;
          end else begin
            cnt     <= cnt + CW'(1);
            sr      <= sr_shift;
            par_acc <= par_acc ^ ser_in;
          end
        end else if (frame_start) begin
          cnt <= '0;
        end

        if (complete && buf_free) begin
          data_out   <= word;
          out_valid  <= 1'b1;
          parity_err <= word_perr;
        end else if (complete) begin
          held_perr <= word_perr;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end else begin
        // Buffer is full and sr holds the next word; refill on consumption.
        if (out_valid && out_ready) begin
          data_out   <= sr;
          parity_err <= held_perr;
          out_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench: one MSB-first and one LSB-first instance fed the same stream.
// Honours PARITY_EN by appending a parity bit to every word.
module tb_shift_deserializer;
  localparam int W = 4;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic clk = 1'b0;
  logic reset, ser_in, ser_valid, frame_start, out_ready;
  logic [1:0] ser_ready_v, out_valid_v, frame_err_v, parity_err_v;
  logic [1:0][W-1:0] data_v;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_w [2][$];
  int exp_p [2][$];
  int cur   [2][$];

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready_v[0]), .frame_start(frame_start), .data_out(data_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .frame_err(frame_err_v[0]),
    .parity_err(parity_err_v[0]));

  shift_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready_v[1]), .frame_start(frame_start), .data_out(data_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .frame_err(frame_err_v[1]),
    .parity_err(parity_err_v[1]));

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic send_bit(input logic b, input logic fs);
    @(negedge clk);
    ser_valid = 1'b1; ser_in = b; frame_start = fs;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    ser_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Stream order is bits[W-1] first; bad_par inverts the parity bit.
  task automatic send_word(input logic [W-1:0] bits, input logic fs, input logic bad_par);
    for (int i = W - 1; i >= 0; i--) send_bit(bits[i], fs && (i == W - 1));
    if (PAR != 0) send_bit((^bits) ^ bad_par, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; ser_in = 0; ser_valid = 0; frame_start = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (data_v[d] !== '0 || out_valid_v[d] !== 1'b0 || frame_err_v[d] !== 1'b0 ||
          parity_err_v[d] !== 1'b0 || ser_ready_v[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset[%0d]: data=%b ov=%b fe=%b pe=%b rdy=%b, want 0 0 0 0 1",
                 d, data_v[d], out_valid_v[d], frame_err_v[d], parity_err_v[d], ser_ready_v[d]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_word(4'b1011, 1'b1, 1'b0);
    n_checks++;
    if (data_v[0] !== 4'b1011 || out_valid_v[0] !== 1'b1 || frame_err_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_msb: data=%b ov=%b fe=%b, want 1011 1 0", data_v[0], out_valid_v[0], frame_err_v[0]);
    end
    n_checks++;
    if (data_v[1] !== 4'b1101 || out_valid_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_lsb: data=%b ov=%b, want 1101 1", data_v[1], out_valid_v[1]);
    end
    n_checks++;
    if (parity_err_v !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_parity: got %b want 00", parity_err_v);
    end
    idle();
    n_checks++;
    if (out_valid_v !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_one_cycle: out_valid=%b want 00", out_valid_v);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_word(4'b1011, 1'b1, 1'b0);
    send_word(4'b0110, 1'b0, 1'b0);
    n_checks++;
    if (data_v[0] !== 4'b1011 || data_v[1] !== rev(4'b1011) || out_valid_v !== 2'b11 ||
        ser_ready_v !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_full: d0=%b d1=%b ov=%b rdy=%b, want 1011 1101 11 00",
               data_v[0], data_v[1], out_valid_v, ser_ready_v);
    end
    send_bit(1'b1, 1'b1);
    n_checks++;
    if (frame_err_v !== 2'b00 || data_v[0] !== 4'b1011 || ser_ready_v !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_fs_in_full: fe=%b d0=%b rdy=%b, want 00 1011 00", frame_err_v, data_v[0], ser_ready_v);
    end
    @(negedge clk);
    ser_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (data_v[0] !== 4'b0110 || data_v[1] !== rev(4'b0110) || out_valid_v !== 2'b11 ||
        ser_ready_v !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_refill: d0=%b d1=%b ov=%b rdy=%b, want 0110 0110 11 11",
               data_v[0], data_v[1], out_valid_v, ser_ready_v);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid_v !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid=%b want 00", out_valid_v);
    end
  endtask

  task automatic test_frame_err();
    logic [W-1:0] w;
    out_ready = 1'b1;
    w = 4'b0101;
    send_bit(1'b1, 1'b1);
    n_checks++;
    if (frame_err_v !== 2'b00) begin
      n_fail++;
      $display("FAIL fs_at_zero: frame_err=%b want 00", frame_err_v);
    end
    send_bit(1'b1, 1'b0);
    send_bit(w[3], 1'b1);
    n_checks++;
    if (frame_err_v !== 2'b11) begin
      n_fail++;
      $display("FAIL fs_pulse: frame_err=%b want 11", frame_err_v);
    end
    send_bit(w[2], 1'b0);
    n_checks++;
    if (frame_err_v !== 2'b00) begin
      n_fail++;
      $display("FAIL fs_one_cycle: frame_err=%b want 00", frame_err_v);
    end
    send_bit(w[1], 1'b0);
    send_bit(w[0], 1'b0);
    if (PAR != 0) send_bit(^w, 1'b0);
    n_checks++;
    if (data_v[0] !== 4'b0101 || data_v[1] !== 4'b1010 || out_valid_v !== 2'b11) begin
      n_fail++;
      $display("FAIL fs_word: d0=%b d1=%b ov=%b, want 0101 1010 11", data_v[0], data_v[1], out_valid_v);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    ser_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (data_v !== '0 || out_valid_v !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: data=%h ov=%b want 0 00", data_v, out_valid_v);
    end
    @(negedge clk);
    reset = 1'b0;
    send_word(4'b1110, 1'b0, 1'b0);
    n_checks++;
    if (data_v[0] !== 4'b1110 || data_v[1] !== 4'b0111 || out_valid_v !== 2'b11) begin
      n_fail++;
      $display("FAIL after_reset: d0=%b d1=%b ov=%b, want 1110 0111 11", data_v[0], data_v[1], out_valid_v);
    end
  endtask

  task automatic test_parity();
`ifdef PARITY_EN
    out_ready = 1'b1;
    send_word(4'b1011, 1'b1, 1'b0);
    n_checks++;
    if (parity_err_v !== 2'b00 || data_v[0] !== 4'b1011) begin
      n_fail++;
      $display("FAIL parity_good: pe=%b d0=%b want 00 1011", parity_err_v, data_v[0]);
    end
    send_word(4'b1011, 1'b1, 1'b1);
    n_checks++;
    if (parity_err_v !== 2'b11 || data_v[0] !== 4'b1011 || out_valid_v !== 2'b11) begin
      n_fail++;
      $display("FAIL parity_bad: pe=%b d0=%b ov=%b want 11 1011 11", parity_err_v, data_v[0], out_valid_v);
    end
`endif
  endtask

  // Scoreboard step: consume against queued words, then record any accepted bit.
  task automatic model_step();
    int w, p, wm, wl, px;
    for (int d = 0; d < 2; d++) begin
      if (out_valid_v[d] && out_ready) begin
        n_checks++;
        if (exp_w[d].size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra[%0d]: got word %b, want none", d, data_v[d]);
        end else begin
          w = exp_w[d].pop_front();
          p = exp_p[d].pop_front();
          if (data_v[d] !== W'(w) || parity_err_v[d] !== p[0]) begin
            n_fail++;
            $display("FAIL rand_word[%0d]: got %b/%b want %b/%b", d, data_v[d], parity_err_v[d], W'(w), p[0]);
          end
        end
      end
      if (ser_valid && ser_ready_v[d]) begin
        cur[d].push_back(int'(ser_in));
        if (cur[d].size() == FL) begin
          wm = 0; wl = 0; px = 0;
          for (int i = 0; i < W; i++) begin
            wm |= cur[d][i] << (W - 1 - i);
            wl |= cur[d][i] << i;
          end
          for (int i = 0; i < FL; i++) px ^= cur[d][i];
          exp_w[d].push_back(d == 0 ? wm : wl);
          exp_p[d].push_back(PAR != 0 ? px : 0);
          cur[d].delete();
        end
      end
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    reset = 1'b1; ser_valid = 0; frame_start = 0; out_ready = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_w[d].delete(); exp_p[d].delete(); cur[d].delete();
    end
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      ser_valid = ($urandom_range(0, 3) != 0);
      ser_in    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      model_step();
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ser_valid = 1'b0; out_ready = 1'b1;
      #1;
      model_step();
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (exp_w[d].size() != 0) begin
        n_fail++;
        $display("FAIL rand_lost[%0d]: %0d words undelivered, want 0", d, exp_w[d].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame_err();
    test_reset_mid();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
